// File: rtl/axi_slave_mem_resp_if.sv
// AXI4 burst slave bus bundle: AW, W, B, AR and R channels.
// Latency: none (wires only).
// Backpressure: plain valid/ready on every channel.
interface axi_slave_mem_resp_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]                    AWLEN;
  logic [1:0]                    AWBURST;
  logic                          AWVALID;
  logic                          AWREADY;
  logic [31:0]                   WDATA;
  logic [3:0]                    WSTRB;
  logic                          WLAST;
  logic                          WVALID;
  logic                          WREADY;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]                    ARLEN;
  logic [1:0]                    ARBURST;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [31:0]                   RDATA;
  logic [1:0]                    RRESP;
  logic                          RLAST;
  logic                          RVALID;
  logic                          RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_slave_mem_resp.sv
// AXI4 burst memory slave: 2^C_MEM_AW x 32-bit words, one outstanding write, one read burst.
// Latency: B one cycle after the last W beat; first R beat one cycle after AR, then back-to-back.
// Backpressure: BVALID/RVALID hold their payload until BREADY/RREADY; AW/AR stall while busy.
module axi_slave_mem_resp #(
  parameter int C_MEM_AW           = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axi_slave_mem_resp_if.slave  s_axi
);

  localparam int         DEPTH       = 1 << C_MEM_AW;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t            w_state, w_state_nxt;
  r_state_t            r_state, r_state_nxt;
  logic                out_en;
  logic                aw_hs, w_hs, r_hs, ar_hs;
  logic                w_len_hit, w_mismatch;

  logic [C_MEM_AW-1:0] w_idx;
  logic [1:0]          w_burst;
  logic [7:0]          w_len, w_cnt;
  logic                w_err;
  logic [1:0]          b_resp;

  logic [C_MEM_AW-1:0] ar_idx, r_idx;
  logic [1:0]          r_burst;
  logic [7:0]          r_len, r_cnt;
  logic [31:0]         r_dat;
  logic                r_last;
  logic [1:0]          r_resp;

  // Handshakes come from state and master inputs only, so no output feeds back.
  assign aw_hs      = (w_state == W_IDLE) && out_en && s_axi.AWVALID;
  assign w_hs       = (w_state == W_DATA) && s_axi.WVALID;
  assign ar_hs      = (r_state == R_IDLE) && out_en && s_axi.ARVALID;
  assign r_hs       = (r_state == R_DATA) && s_axi.RREADY;
  assign ar_idx     = s_axi.ARADDR[C_MEM_AW+1:2];
  assign w_len_hit  = (w_cnt == w_len);
  assign w_mismatch = (s_axi.WLAST != w_len_hit);

  assign s_axi.BRESP = b_resp;
  assign s_axi.RDATA = r_dat;
  assign s_axi.RLAST = r_last;
  assign s_axi.RRESP = r_resp;

  // Keep AWREADY/ARREADY low until the first clock edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) out_en <= 1'b0;
    else          out_en <= 1'b1;
  end

  // State registers for both channel FSMs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Write FSM next state and channel ready/valid outputs.
  always_comb begin
    w_state_nxt   = w_state;
    s_axi.AWREADY = 1'b0;
    s_axi.WREADY  = 1'b0;
    s_axi.BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi.AWREADY = out_en;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.WREADY = 1'b1;
        if (s_axi.WVALID && s_axi.WLAST) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.BVALID = 1'b1;
        if (s_axi.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM next state and channel ready/valid outputs.
  always_comb begin
    r_state_nxt   = r_state;
    s_axi.ARREADY = 1'b0;
    s_axi.RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.ARREADY = out_en;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi.RVALID = 1'b1;
        if (s_axi.RREADY && r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write burst tracking: index, beat count and sticky error that becomes BRESP.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_idx   <= '0;
      w_burst <= BURST_FIXED;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_idx   <= s_axi.AWADDR[C_MEM_AW+1:2];
      w_burst <= s_axi.AWBURST;
      w_len   <= s_axi.AWLEN;
      w_cnt   <= '0;
      w_err   <= (s_axi.AWBURST == BURST_WRAP);
    end else if (w_hs) begin
      if (w_burst != BURST_FIXED) w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
      // Any beat where WLAST disagrees with the AWLEN position taints the burst.
      if (w_mismatch) w_err <= 1'b1;
      if (s_axi.WLAST) b_resp <= (w_err || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Memory array write with byte enables; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.WSTRB[b]) mem[w_idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
      end
    end
  end

  // Read datapath: preload the next word on each accepted non-last beat so beats are back-to-back.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_idx   <= '0;
      r_burst <= BURST_FIXED;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dat   <= '0;
      r_last  <= 1'b0;
      r_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_dat   <= mem[ar_idx];
      r_idx   <= (s_axi.ARBURST == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
      r_burst <= s_axi.ARBURST;
      r_len   <= s_axi.ARLEN;
      r_cnt   <= '0;
      r_last  <= (s_axi.ARLEN == 8'd0);
      r_resp  <= (s_axi.ARBURST == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs && !r_last) begin
      r_dat  <= mem[r_idx];
      if (r_burst != BURST_FIXED) r_idx <= r_idx + 1'b1;
      r_cnt  <= r_cnt + 8'd1;
      r_last <= ((r_cnt + 8'd1) == r_len);
    end
  end

endmodule
